// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, instruction/PC widths,
// default NOP encoding and the fetch buffer entry layout.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 64;

  // addi x0, x0, 0
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h00000013;

  // REQ: may issue, WAIT: one request outstanding, DROP: outstanding response is stale
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Bits needed to hold an occupancy value in 0..depth
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, inst} entries.
// clear wins over push/pop; push on full is only taken with a same-cycle pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = $bits(fetch_entry_t),
  localparam int CW   = cnt_w(DEPTH),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // a full FIFO only takes a push when the head leaves in the same cycle
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // storage write; contents need no reset since occupancy guards reads
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// buffers responses tagged with their PC, and hands them to decode.
// flush discards both buffered entries and any request still in flight.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                 FIFO_DEPTH = 2,
  parameter logic [INST_W-1:0]  NOP_INST   = NOP_INST_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              pc_stall_o,
  input  logic              flush_i,
  output logic              imem_req_valid_o,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              id_valid_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [PC_W-1:0]   id_pc_o,
  input  logic              id_ready_i
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [PC_W-1:0]  r_req_pc;

  logic             w_req_valid;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_wentry;

  // Issue only when a buffer slot is guaranteed for the response; since at
  // most one request is in flight, a free slot now is still free on return.
  assign w_req_valid = rst_n_i & (r_state == FS_REQ) & ~w_full & ~flush_i;
  assign w_accept    = w_req_valid & imem_req_ready_i;
  assign w_push      = (r_state == FS_WAIT) & imem_rsp_valid_i & ~flush_i;
  assign w_pop       = rst_n_i & (w_count != '0) & id_ready_i & ~flush_i;

  assign w_wentry.pc   = r_req_pc;
  assign w_wentry.inst = imem_rsp_data_i;

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = pc_i;
  // PC moves once per accepted request and on every redirect
  assign pc_stall_o       = ~rst_n_i | (~w_accept & ~flush_i);

  assign id_valid_o = rst_n_i & (w_count != '0);
  assign id_inst_o  = (~rst_n_i | w_empty) ? NOP_INST    : w_head.inst;
  assign id_pc_o    = (~rst_n_i | w_empty) ? {PC_W{1'b0}} : w_head.pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (flush_i),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // next-state: track the single outstanding request and whether it is stale
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_REQ:  if (w_accept) w_state_nxt = FS_WAIT;
      FS_WAIT: begin
        if (flush_i)               w_state_nxt = imem_rsp_valid_i ? FS_REQ : FS_DROP;
        else if (imem_rsp_valid_i) w_state_nxt = FS_REQ;
      end
      // the stale response is consumed whenever it shows up; a further
      // flush while waiting for it just keeps us here
      FS_DROP: if (imem_rsp_valid_i) w_state_nxt = FS_REQ;
      default: w_state_nxt = FS_REQ;
    endcase
  end

  // state register; reset forgets any request in flight
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= FS_REQ;
    else          r_state <= w_state_nxt;
  end

  // PC of the outstanding request, used to tag its response
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)      r_req_pc <= '0;
    else if (w_accept) r_req_pc <= pc_i;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run, checked by a
// per-cycle monitor against a queue-based model of the fetch buffer.
module tb_inst_fetch;
  import cpu_pkg::*;

  localparam int          D   = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc_i;
  logic        pc_stall_o;
  logic        flush_i;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [63:0] id_pc_o;
  logic        id_ready_i;

  always #5 clk = ~clk;

  inst_fetch #(.FIFO_DEPTH(D), .NOP_INST(NOP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc_i), .pc_stall_o(pc_stall_o),
    .flush_i(flush_i), .imem_req_valid_o(imem_req_valid_o),
    .imem_req_addr_o(imem_req_addr_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
    .id_ready_i(id_ready_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] ^ 32'h1234_5678) * 32'h9E37_79B1;
  endfunction

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  // model: instructions waiting for decode, plus the single in-flight request
  ent_t        q[$];
  ent_t        got[$];
  bit          busy, drop;
  logic [63:0] mreq_pc;
  int          cyc = 0;
  int          acc_cyc[$];

  // observations handed to the stimulus side (memory + PC register)
  bit          acc_seen = 0;
  logic [63:0] acc_addr;
  bit          last_stall = 1, last_flush = 0;

  // monitor: compare against the model, then advance the model by one cycle
  always @(negedge clk) begin : mon
    bit   ev, es, acc, pop, push;
    ent_t e;
    cyc++;
    if (!rst_n) begin
      chk("rst_req_valid", imem_req_valid_o, 0);
      chk("rst_pc_stall", pc_stall_o, 1);
      chk("rst_id_valid", id_valid_o, 0);
      chk("rst_id_inst", id_inst_o, NOP);
      chk("rst_id_pc", id_pc_o, 0);
      q.delete();
      busy = 0; drop = 0; acc_seen = 0;
      last_stall = pc_stall_o; last_flush = 0;
    end else begin
      ev = !busy && (q.size() < D) && !flush_i;
      chk("req_valid", imem_req_valid_o, ev);
      if (ev) chk("req_addr", imem_req_addr_o, pc_i);
      acc = ev && imem_req_ready_i;
      es  = !acc && !flush_i;
      chk("pc_stall", pc_stall_o, es);
      chk("id_valid", id_valid_o, q.size() != 0);
      if (q.size() != 0) begin
        chk("id_pc", id_pc_o, q[0].pc);
        chk("id_inst", id_inst_o, q[0].inst);
      end else begin
        chk("id_pc_empty", id_pc_o, 0);
        chk("id_inst_empty", id_inst_o, NOP);
      end
      pop  = (q.size() != 0) && id_ready_i && !flush_i;
      push = busy && imem_rsp_valid_i && !drop && !flush_i;
      if (busy && imem_rsp_valid_i) busy = 0;
      else if (busy && flush_i)     drop = 1;
      if (flush_i) q.delete();
      if (pop) begin
        e = q.pop_front();
        got.push_back('{id_pc_o, id_inst_o});
      end
      if (push) begin
        chk("fifo_no_overflow", q.size() < D, 1);
        q.push_back('{mreq_pc, imem_rsp_data_i});
      end
      if (acc) begin
        busy = 1; drop = 0; mreq_pc = pc_i;
        acc_cyc.push_back(cyc);
      end
      acc_seen   = imem_req_valid_o && imem_req_ready_i;
      acc_addr   = imem_req_addr_o;
      last_stall = pc_stall_o;
      last_flush = flush_i;
    end
  end

  // stimulus side: external PC register and an auto-responding memory
  logic [63:0] tgt = 64'h0;
  bit          auto_rsp = 0;
  int          lat_max = 1;
  bit          mem_pend = 0;
  int          mem_cnt;
  logic [63:0] mem_addr;

  task automatic step();
    @(posedge clk); #1;
    if (!last_stall) pc_i = last_flush ? tgt : pc_i + 64'd4;
    if (auto_rsp) begin
      imem_rsp_valid_i = 1'b0;
      if (acc_seen) begin
        mem_pend = 1; mem_addr = acc_addr;
        mem_cnt  = $urandom_range(lat_max, 1);
      end
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = memf(mem_addr);
          mem_pend = 0;
        end
      end
    end
  endtask

  task automatic do_reset(input logic [63:0] pc0);
    rst_n = 0; flush_i = 0; imem_req_ready_i = 0; id_ready_i = 0;
    imem_rsp_valid_i = 0; auto_rsp = 0; mem_pend = 0; lat_max = 1;
    repeat (2) step();
    pc_i = pc0; rst_n = 1;
    got.delete(); acc_cyc.delete();
  endtask

  initial begin
    rst_n = 0; pc_i = 0; flush_i = 0; imem_req_ready_i = 0;
    imem_rsp_valid_i = 0; imem_rsp_data_i = 0; id_ready_i = 0;

    // back-to-back flow, one accept every two cycles
    do_reset(64'h0);
    imem_req_ready_i = 1; id_ready_i = 1; auto_rsp = 1;
    repeat (8) step();
    chk("t1_delivered", got.size() >= 3, 1);
    if (got.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk("t1_pc", got[i].pc, 64'(i * 4));
        chk("t1_inst", got[i].inst, memf(64'(i * 4)));
      end
    chk("t1_accepts", acc_cyc.size() >= 3, 1);
    if (acc_cyc.size() >= 3) begin
      chk("t1_gap0", acc_cyc[1] - acc_cyc[0], 2);
      chk("t1_gap1", acc_cyc[2] - acc_cyc[1], 2);
    end

    // backpressure fills exactly D entries, then drains in order
    do_reset(64'h0);
    imem_req_ready_i = 1; id_ready_i = 0; auto_rsp = 1;
    repeat (8) step();
    @(negedge clk);
    chk("t2_req_held", imem_req_valid_o, 0);
    chk("t2_stall_held", pc_stall_o, 1);
    chk("t2_head_pc", id_pc_o, 64'h0);
    chk("t2_accepts", acc_cyc.size(), D);
    step();
    id_ready_i = 1;
    repeat (6) step();
    chk("t2_drained", got.size() >= 2, 1);
    if (got.size() >= 2) begin
      chk("t2_pc0", got[0].pc, 64'h0);
      chk("t2_pc1", got[1].pc, 64'h4);
    end
    chk("t2_resumed", acc_cyc.size() > D, 1);

    // flush while waiting: late response dropped, redirect target fetched
    do_reset(64'h100);
    imem_req_ready_i = 1; id_ready_i = 1;
    step();
    flush_i = 1; tgt = 64'h200;
    step();
    flush_i = 0;
    @(negedge clk);
    chk("t3_drop_no_req", imem_req_valid_o, 0);
    step();
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t3_stale_not_shown", id_valid_o, 0);
    step();
    imem_rsp_valid_i = 0; auto_rsp = 1;
    @(negedge clk);
    chk("t3_redirect_req", imem_req_valid_o, 1);
    chk("t3_redirect_addr", imem_req_addr_o, 64'h200);
    repeat (4) step();
    chk("t3_delivered", got.size() >= 1, 1);
    if (got.size() >= 1) begin
      chk("t3_pc", got[0].pc, 64'h200);
      chk("t3_inst", got[0].inst, memf(64'h200));
    end

    // flush coincident with a response while one entry is buffered
    do_reset(64'h0);
    imem_req_ready_i = 1; id_ready_i = 0; auto_rsp = 1;
    for (int k = 0; k < 20 && !(imem_rsp_valid_i && q.size() == 1); k++) step();
    chk("t4_reached", imem_rsp_valid_i && q.size() == 1, 1);
    flush_i = 1; tgt = 64'h40;
    step();
    flush_i = 0;
    @(negedge clk);
    chk("t4_id_valid", id_valid_o, 0);
    chk("t4_fsm_req", imem_req_valid_o, 1);
    chk("t4_addr", imem_req_addr_o, 64'h40);

    // memory not ready: request held stable, PC held
    do_reset(64'h300);
    imem_req_ready_i = 0; id_ready_i = 1; auto_rsp = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_valid_held", imem_req_valid_o, 1);
      chk("t5_addr_stable", imem_req_addr_o, 64'h300);
      chk("t5_stall", pc_stall_o, 1);
      step();
    end
    imem_req_ready_i = 1;
    @(negedge clk);
    chk("t5_accept_stall", pc_stall_o, 0);
    step();
    chk("t5_pc_once", pc_i, 64'h304);
    @(negedge clk);
    chk("t5_wait_no_req", imem_req_valid_o, 0);

    // reset while waiting: stale response ignored, fetch restarts at 0
    do_reset(64'h500);
    imem_req_ready_i = 1; id_ready_i = 1;
    step();
    rst_n = 0;
    step();
    imem_rsp_valid_i = 1; imem_rsp_data_i = 32'hDEADBEEF; pc_i = 64'h0;
    step();
    rst_n = 1; imem_req_ready_i = 0;
    @(negedge clk);
    chk("t6_id_valid", id_valid_o, 0);
    chk("t6_req_after_rst", imem_req_valid_o, 1);
    step();
    imem_rsp_valid_i = 0; imem_req_ready_i = 1; auto_rsp = 1;
    @(negedge clk);
    chk("t6_first_addr", imem_req_addr_o, 64'h0);
    repeat (4) step();
    chk("t6_delivered", got.size() >= 1, 1);
    if (got.size() >= 1) begin
      chk("t6_pc", got[0].pc, 64'h0);
      chk("t6_inst", got[0].inst, memf(64'h0));
    end

    // randomized traffic with flushes, stalls and variable memory latency
    do_reset(64'h0);
    auto_rsp = 1; lat_max = 3;
    for (int n = 0; n < 3000; n++) begin
      step();
      imem_req_ready_i = ($urandom_range(9, 0) < 7);
      id_ready_i       = ($urandom_range(9, 0) < 6);
      tgt              = {$urandom(), $urandom()} & ~64'h3;
      flush_i          = ($urandom_range(15, 0) == 0) && !(imem_rsp_valid_i && drop);
    end
    step();
    flush_i = 0; imem_req_ready_i = 0; id_ready_i = 0;
    chk("rand_progress", got.size() > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
